// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg
//   Shared constants and types for the clock divider bank.
//   - CDB_* constants: default parameter values for the bank and its channels.
//   - speed_ev_e: decoded speed event, produced by a fixed-priority encoder.
//   - encode_event(): priority encoder, reset > up > down.
package clock_divider_pkg;

  localparam int unsigned CDB_WIDTH        = 32;
  localparam int unsigned CDB_NUM_CH       = 2;
  localparam int unsigned CDB_DEFAULT_HALF = 1216;
  localparam int unsigned CDB_STEP         = 100;
  localparam int unsigned CDB_MIN_HALF     = 16;
  localparam int unsigned CDB_MAX_HALF     = 100000;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_RESET,
    EV_UP,
    EV_DOWN
  } speed_ev_e;

  // At most one period update per cycle; a reset request masks the others,
  // and speed-up masks speed-down.
  function automatic speed_ev_e encode_event(input logic reset_ev,
                                             input logic up_ev,
                                             input logic down_ev);
    speed_ev_e ev;
    ev = EV_NONE;
    if (reset_ev) begin
      ev = EV_RESET;
    end else if (up_ev) begin
      ev = EV_UP;
    end else if (down_ev) begin
      ev = EV_DOWN;
    end
    return ev;
  endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// clock_divider_ch
//   One channel of the divider bank: a half-period counter producing a 50%
//   duty divided clock, a one-cycle toggle strobe, and a saturating pending
//   half-period register that is adopted only at toggle boundaries.
// Ports
//   clk               system clock, rising edge
//   reset_n           asynchronous active-low reset
//   enable            run; when low counter/outclk/active period hold
//   speed_up_event    shorten pending half period by STEP (saturates at MIN_HALF)
//   speed_down_event  lengthen pending half period by STEP (saturates at MAX_HALF)
//   speed_reset_event restore pending half period to DEFAULT_HALF
//   outclk            divided clock (registered)
//   tick              one-cycle pulse on the edge outclk toggles
//   half_period       pending half-period value
//   at_min, at_max    pending value sits on the lower / upper bound
module clock_divider_ch
  import clock_divider_pkg::*;
#(
  parameter int unsigned WIDTH        = CDB_WIDTH,
  parameter int unsigned DEFAULT_HALF = CDB_DEFAULT_HALF,
  parameter int unsigned STEP         = CDB_STEP,
  parameter int unsigned MIN_HALF     = CDB_MIN_HALF,
  parameter int unsigned MAX_HALF     = CDB_MAX_HALF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             speed_up_event,
  input  logic             speed_down_event,
  input  logic             speed_reset_event,
  output logic             outclk,
  output logic             tick,
  output logic [WIDTH-1:0] half_period,
  output logic             at_min,
  output logic             at_max
);

  // Parameter sanity; MIN_HALF >= 1 also guarantees tick never stays high
  // on consecutive cycles.
  generate
    if (!(MIN_HALF > 0 && MIN_HALF <= DEFAULT_HALF && DEFAULT_HALF <= MAX_HALF &&
          (WIDTH >= 32 || 64'(MAX_HALF) < (64'd1 << WIDTH)))) begin : g_bad_bounds
      $fatal(1, "clock_divider_ch: need 0 < MIN_HALF <= DEFAULT_HALF <= MAX_HALF < 2**WIDTH");
    end
    if (STEP == 0) begin : g_bad_step
      $fatal(1, "clock_divider_ch: STEP must be non-zero");
    end
  endgenerate

  localparam logic [WIDTH-1:0] DEFAULT_W = WIDTH'(DEFAULT_HALF);
  localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(MIN_HALF);
  localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_HALF);
  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
  // One extra bit so the saturation compares cannot wrap.
  localparam logic [WIDTH:0]   MIN_EXT   = (WIDTH+1)'(MIN_HALF);
  localparam logic [WIDTH:0]   MAX_EXT   = (WIDTH+1)'(MAX_HALF);
  localparam logic [WIDTH:0]   STEP_EXT  = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] counter_reg, counter_next;
  logic [WIDTH-1:0] active_half_reg, active_half_next;
  logic [WIDTH-1:0] pending_half_reg, pending_half_next;
  logic             outclk_reg, outclk_next;
  logic             tick_reg, tick_next;

  speed_ev_e        ev;
  logic [WIDTH:0]   pending_ext;

  // Pending half-period update: events are accepted regardless of enable.
  always_comb begin
    ev                = encode_event(speed_reset_event, speed_up_event, speed_down_event);
    pending_ext       = {1'b0, pending_half_reg};
    pending_half_next = pending_half_reg;
    unique case (ev)
      EV_RESET: pending_half_next = DEFAULT_W;
      EV_UP: begin
        if (pending_ext < MIN_EXT + STEP_EXT) begin
          pending_half_next = MIN_W;
        end else begin
          pending_half_next = pending_half_reg - STEP_W;
        end
      end
      EV_DOWN: begin
        // Equivalent to pending > MAX - STEP, without underflow when STEP > MAX.
        if (pending_ext + STEP_EXT > MAX_EXT) begin
          pending_half_next = MAX_W;
        end else begin
          pending_half_next = pending_half_reg + STEP_W;
        end
      end
      default: pending_half_next = pending_half_reg;
    endcase
  end

  // Counter and toggle. The active period is only replaced on the boundary
  // cycle, so the half in progress always completes at its original length.
  // An event landing on the boundary cycle is not yet in pending_half_reg,
  // so it takes effect one half later.
  always_comb begin
    counter_next     = counter_reg;
    active_half_next = active_half_reg;
    outclk_next      = outclk_reg;
    tick_next        = 1'b0;
    if (enable) begin
      if (counter_reg == active_half_reg) begin
        counter_next     = '0;
        outclk_next      = ~outclk_reg;
        tick_next        = 1'b1;
        active_half_next = pending_half_reg;
      end else begin
        counter_next = counter_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_reg      <= '0;
      active_half_reg  <= DEFAULT_W;
      pending_half_reg <= DEFAULT_W;
      outclk_reg       <= 1'b0;
      tick_reg         <= 1'b0;
    end else begin
      counter_reg      <= counter_next;
      active_half_reg  <= active_half_next;
      pending_half_reg <= pending_half_next;
      outclk_reg       <= outclk_next;
      tick_reg         <= tick_next;
    end
  end

  assign outclk      = outclk_reg;
  assign tick        = tick_reg;
  assign half_period = pending_half_reg;
  assign at_min      = (pending_half_reg == MIN_W);
  assign at_max      = (pending_half_reg == MAX_W);

endmodule

// File: rtl/clock_divider_bank.sv
// clock_divider_bank
//   NUM_CH independent divided-clock channels, each with its own enable and
//   speed-up / speed-down / speed-reset controls.
// Ports
//   clk, reset_n       system clock; asynchronous active-low reset
//   enable[i]          channel i run
//   speed_*_event[i]   channel i period controls (one-cycle pulses)
//   outclk[i], tick[i] channel i divided clock and toggle strobe
//   half_period        channel i pending half period at [i*WIDTH +: WIDTH]
//   at_min[i], at_max[i] channel i pending value on the lower / upper bound
module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter int unsigned WIDTH        = CDB_WIDTH,
  parameter int unsigned NUM_CH       = CDB_NUM_CH,
  parameter int unsigned DEFAULT_HALF = CDB_DEFAULT_HALF,
  parameter int unsigned STEP         = CDB_STEP,
  parameter int unsigned MIN_HALF     = CDB_MIN_HALF,
  parameter int unsigned MAX_HALF     = CDB_MAX_HALF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       speed_up_event,
  input  logic [NUM_CH-1:0]       speed_down_event,
  input  logic [NUM_CH-1:0]       speed_reset_event,
  output logic [NUM_CH-1:0]       outclk,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH*WIDTH-1:0] half_period,
  output logic [NUM_CH-1:0]       at_min,
  output logic [NUM_CH-1:0]       at_max
);

  generate
    if (NUM_CH < 1) begin : g_bad_num_ch
      $fatal(1, "clock_divider_bank: NUM_CH must be at least 1");
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clock_divider_ch #(
        .WIDTH       (WIDTH),
        .DEFAULT_HALF(DEFAULT_HALF),
        .STEP        (STEP),
        .MIN_HALF    (MIN_HALF),
        .MAX_HALF    (MAX_HALF)
      ) u_ch (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable[gi]),
        .speed_up_event   (speed_up_event[gi]),
        .speed_down_event (speed_down_event[gi]),
        .speed_reset_event(speed_reset_event[gi]),
        .outclk           (outclk[gi]),
        .tick             (tick[gi]),
        .half_period      (half_period[gi*WIDTH +: WIDTH]),
        .at_min           (at_min[gi]),
        .at_max           (at_max[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank
//   Directed bench for clock_divider_bank with WIDTH=8, NUM_CH=2,
//   DEFAULT_HALF=4, STEP=2, MIN_HALF=2, MAX_HALF=8. Edge numbers in the
//   comments count rising edges from the second channel-0 toggle (edge 0).
module tb_clock_divider_bank;

  logic        clk;
  logic        reset_n;
  logic [1:0]  enable;
  logic [1:0]  speed_up_event;
  logic [1:0]  speed_down_event;
  logic [1:0]  speed_reset_event;
  logic [1:0]  outclk;
  logic [1:0]  tick;
  logic [15:0] half_period;
  logic [1:0]  at_min;
  logic [1:0]  at_max;

  int tests_run    = 0;
  int tests_failed = 0;

  clock_divider_bank #(
    .WIDTH       (8),
    .NUM_CH      (2),
    .DEFAULT_HALF(4),
    .STEP        (2),
    .MIN_HALF    (2),
    .MAX_HALF    (8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .speed_up_event   (speed_up_event),
    .speed_down_event (speed_down_event),
    .speed_reset_event(speed_reset_event),
    .outclk           (outclk),
    .tick             (tick),
    .half_period      (half_period),
    .at_min           (at_min),
    .at_max           (at_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    $display("[TB] %s: observed %0h expected %0h", tag, obs, exp_v);
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until tick[ch] is seen; bounded so a dead channel fails.
  task automatic wait_tick(input int ch, input int exp_n, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < 40);
    check(tag, n, exp_n);
  endtask

  initial begin
    reset_n           = 1'b1;
    enable            = 2'b00;
    speed_up_event    = 2'b00;
    speed_down_event  = 2'b00;
    speed_reset_event = 2'b00;

    // Reset state, no clock edge yet.
    #2 reset_n = 1'b0;
    #1;
    check("rst_outclk", outclk, 2'b00);
    check("rst_tick", tick, 2'b00);
    check("rst_half_period", half_period, 16'h0404);
    check("rst_at_min", at_min, 2'b00);
    check("rst_at_max", at_max, 2'b00);
    step();
    step();
    check("rst_held_outclk", outclk, 2'b00);

    // Release: first rise on the 5th edge.
    reset_n = 1'b1;
    enable  = 2'b11;
    repeat (4) step();
    check("pre_rise_outclk", outclk, 2'b00);
    check("pre_rise_tick", tick, 2'b00);
    step();
    check("first_rise_outclk", outclk, 2'b11);
    check("first_rise_tick", tick, 2'b11);
    wait_tick(0, 5, "default_half_len");             // edge 0
    check("e0_outclk", outclk, 2'b00);
    check("e0_tick", tick, 2'b11);
    step();
    check("tick_single_cycle", tick, 2'b00);

    // speed_up on ch0 two cycles into the half.
    step();                                          // edge 2
    speed_up_event = 2'b01;
    step();                                          // edge 3
    speed_up_event = 2'b00;
    check("up1_hp0", half_period[7:0], 8'd2);
    check("up1_at_min", at_min, 2'b01);
    check("up1_hp1", half_period[15:8], 8'd4);
    wait_tick(0, 2, "half_in_progress_len");         // edge 5
    check("e5_outclk", outclk, 2'b11);
    check("e5_tick", tick, 2'b11);
    wait_tick(0, 3, "half_after_up");                // edge 8
    check("e8_tick", tick, 2'b01);

    // Two more speed_up pulses: stays saturated at MIN.
    speed_up_event = 2'b01;
    step();                                          // edge 9
    check("up2_hp0", half_period[7:0], 8'd2);
    check("up2_at_min", at_min, 2'b01);
    step();                                          // edge 10
    speed_up_event = 2'b00;
    check("up3_hp0", half_period[7:0], 8'd2);
    wait_tick(0, 1, "min_half_len");                 // edge 11
    wait_tick(1, 4, "ch1_unchanged_a");              // edge 15
    wait_tick(1, 5, "ch1_unchanged_b");              // edge 20

    // Three speed_down pulses on ch1: 6, 8, 8.
    speed_down_event = 2'b10;
    step();                                          // edge 21
    check("dn1_hp1", half_period[15:8], 8'd6);
    check("dn1_at_max", at_max, 2'b00);
    step();                                          // edge 22
    check("dn2_hp1", half_period[15:8], 8'd8);
    check("dn2_at_max", at_max, 2'b10);
    step();                                          // edge 23
    speed_down_event = 2'b00;
    check("dn3_hp1", half_period[15:8], 8'd8);
    check("dn3_at_max", at_max, 2'b10);
    wait_tick(1, 2, "ch1_half_before_down");         // edge 25
    wait_tick(1, 9, "ch1_half_after_down");          // edge 34

    // Priority: reset beats up and down; up beats down.
    speed_reset_event = 2'b10;
    speed_up_event    = 2'b10;
    speed_down_event  = 2'b10;
    step();                                          // edge 35
    check("prio_reset_hp1", half_period[15:8], 8'd4);
    check("prio_reset_at_max", at_max, 2'b00);
    speed_reset_event = 2'b00;
    step();                                          // edge 36
    speed_up_event   = 2'b00;
    speed_down_event = 2'b00;
    check("prio_up_hp1", half_period[15:8], 8'd2);
    check("prio_up_at_min", at_min, 2'b11);

    // Enable hold on ch0, one cycle into a half.
    wait_tick(0, 2, "ch0_sync");                     // edge 38
    check("e38_tick", tick, 2'b01);
    check("e38_outclk0", outclk[0], 1'b0);
    step();                                          // edge 39
    enable = 2'b10;
    for (int i = 0; i < 7; i++) begin                // edges 40..46
      speed_down_event = (i == 1) ? 2'b01 : 2'b00;
      speed_up_event   = (i == 2) ? 2'b01 : 2'b00;
      step();
      check($sformatf("hold%0d_outclk0", i), outclk[0], 1'b0);
      check($sformatf("hold%0d_tick0", i), tick[0], 1'b0);
      if (i == 1) check("hold_down_hp0", half_period[7:0], 8'd4);
      if (i == 2) check("hold_up_hp0", half_period[7:0], 8'd2);
    end
    speed_down_event = 2'b00;
    speed_up_event   = 2'b00;
    enable           = 2'b11;
    wait_tick(0, 2, "resume_remaining");             // edge 48
    check("resume_outclk0", outclk[0], 1'b1);

    // Asynchronous reset mid-half, between edges.
    step();                                          // edge 49
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_outclk", outclk, 2'b00);
    check("async_rst_tick", tick, 2'b00);
    check("async_rst_hp", half_period, 16'h0404);
    check("async_rst_at_min", at_min, 2'b00);
    step();
    reset_n = 1'b1;
    repeat (4) step();
    check("rerelease_pre_rise", outclk, 2'b00);
    step();
    check("rerelease_rise_outclk", outclk, 2'b11);
    check("rerelease_rise_tick", tick, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
